// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared multicycle memory to the I-cache fill, D-cache fill
// or D-cache write-through path, and sequences each block fill or single store.
module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int WORDS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_req,
  input  logic [15:0] icache_addr,
  input  logic        dcache_req,
  input  logic [15:0] dcache_addr,
  input  logic        dcache_wr_req,
  input  logic [15:0] dcache_wr_addr,
  input  logic [15:0] dcache_wr_data,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data_in,
  output logic        icache_grant,
  output logic        dcache_grant,
  output logic        icache_data_valid,
  output logic        dcache_data_valid,
  output logic [15:0] fill_data,
  output logic        fill_done,
  output logic        wr_done,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_out
);
  typedef enum logic [1:0] {IDLE, IFILL, DFILL, DWRITE} state_t;
  localparam logic [3:0] W_MAX  = 4'(WORDS);
  localparam logic [3:0] W_LAST = 4'(WORDS - 1);
  state_t      r_state, w_next;
  logic [15:0] r_base, r_wdata;
  logic [3:0]  r_issue, r_rcv;
  logic        r_last;
  logic        w_fill, w_issue, w_last_word, w_pick_d, w_fv, w_unused;
  // Read-data timing is tracked by counting returns, so LATENCY and the offset bits are unused.
  assign w_unused    = ^{icache_addr[3:0], dcache_addr[3:0], LATENCY[0]};
  assign w_fill      = r_state == IFILL || r_state == DFILL;
  assign w_issue     = w_fill && r_issue < W_MAX;
  assign w_last_word = w_fill && mem_data_valid && r_rcv == W_LAST;
  // Both misses pending: the D-cache wins only if the I-cache was served last.
  assign w_pick_d    = dcache_req && (!icache_req || !r_last);
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:         w_next = dcache_wr_req ? DWRITE : w_pick_d ? DFILL : icache_req ? IFILL : IDLE;
      IFILL, DFILL: w_next = w_last_word ? IDLE : r_state;
      default:      w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_wdata <= '0;
      r_issue <= '0;
      r_rcv   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        r_issue <= '0;
        r_rcv   <= '0;
        r_base  <= dcache_wr_req ? dcache_wr_addr :
                   w_pick_d ? {dcache_addr[15:4], 4'h0} : {icache_addr[15:4], 4'h0};
        r_wdata <= dcache_wr_data;
      end else begin
        if (w_issue) r_issue <= r_issue + 4'd1;
        if (w_fill && mem_data_valid) r_rcv <= r_rcv + 4'd1;
      end
      if (w_last_word) r_last <= r_state == DFILL;
    end
  assign icache_grant      = r_state == IFILL;
  assign dcache_grant      = r_state == DFILL || r_state == DWRITE;
  assign icache_data_valid = r_state == IFILL && mem_data_valid;
  assign dcache_data_valid = r_state == DFILL && mem_data_valid;
  assign w_fv              = icache_data_valid || dcache_data_valid;
  assign fill_data         = w_fv ? mem_data_in : 16'h0;
  assign fill_done         = w_last_word;
  assign wr_done           = r_state == DWRITE;
  assign mem_wr            = r_state == DWRITE;
  assign mem_enable        = w_issue || mem_wr;
  assign mem_addr          = w_issue ? r_base + {11'b0, r_issue, 1'b0} : mem_wr ? r_base : 16'h0;
  assign mem_data_out      = mem_wr ? r_wdata : 16'h0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard of expected memory accesses and fill returns.
module tb_mem_arbiter;
  localparam int WORDS = 8;
  typedef struct {logic wr; logic [15:0] addr; logic [15:0] data;} mem_t;
  typedef struct {logic iv; logic dv; logic [15:0] data; logic done;} ret_t;
  typedef struct {int due; logic [15:0] data;} pend_t;
  logic clk = 0, rst = 1;
  logic icache_req = 0, dcache_req = 0, dcache_wr_req = 0, mem_data_valid = 0;
  logic [15:0] icache_addr = 0, dcache_addr = 0, dcache_wr_addr = 0, dcache_wr_data = 0, mem_data_in = 0;
  logic icache_grant, dcache_grant, icache_data_valid, dcache_data_valid, fill_done, wr_done, mem_enable, mem_wr;
  logic [15:0] fill_data, mem_addr, mem_data_out;
  mem_t  exp_mem[$];
  ret_t  exp_ret[$];
  pend_t pend[$];
  int n_chk = 0, n_fail = 0, cyc = 0, lat = 4, ret_seen = 0, done_cyc = -1;
  mem_arbiter #(.LATENCY(4), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .dcache_req(dcache_req), .dcache_addr(dcache_addr),
    .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr), .dcache_wr_data(dcache_wr_data),
    .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
    .icache_grant(icache_grant), .dcache_grant(dcache_grant),
    .icache_data_valid(icache_data_valid), .dcache_data_valid(dcache_data_valid),
    .fill_data(fill_data), .fill_done(fill_done), .wr_done(wr_done),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_out(mem_data_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return {8'h0, icache_grant, dcache_grant, icache_data_valid, dcache_data_valid, fill_done,
            wr_done, mem_enable, mem_wr, fill_data, mem_addr, mem_data_out};
  endfunction
  task automatic push_fill(input bit d, input logic [15:0] a);
    logic [15:0] b, w;
    b = {a[15:4], 4'h0};
    for (int i = 0; i < WORDS; i++) begin
      w = b + 16'(2 * i);
      exp_mem.push_back('{1'b0, w, 16'h0});
      exp_ret.push_back('{!d, d, w ^ 16'h5A5A, i == WORDS - 1});
    end
  endtask
  // Called at a negedge; waits for the grant, optionally drops both requests, then times the fill.
  task automatic track_fill(input bit d, input int g_exp, input bit drop, output int g);
    int n;
    n = 0;
    while (!(icache_grant || dcache_grant) && n < 40) begin @(negedge clk); n++; end
    g = cyc;
    chk("grant_cycle", g, g_exp);
    chk("grant_owner", {icache_grant, dcache_grant}, d ? 2'b01 : 2'b10);
    if (drop) begin icache_req = 0; dcache_req = 0; end
    n = 0;
    while ((icache_grant || dcache_grant) && n < 40) begin @(negedge clk); n++; end
    chk("fill_done_cycle", done_cyc, g + lat + WORDS - 1);
    chk("grant_drop_cycle", cyc, g + lat + WORDS);
  endtask
  // Memory model: a read issued in cycle c returns in cycle c+lat.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_data_valid = 1;
      mem_data_in = pend[0].data;
      void'(pend.pop_front());
    end else begin
      mem_data_valid = 0;
      mem_data_in = 0;
    end
  end
  initial begin
    mem_t me;
    ret_t re;
    forever begin
      @(negedge clk);
      if (mem_enable) begin
        if (exp_mem.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL mem_unexpected: got access at %h expected none", mem_addr);
        end else begin
          me = exp_mem.pop_front();
          chk("mem_access", {mem_wr, wr_done, mem_addr, mem_data_out}, {me.wr, me.wr, me.addr, me.data});
        end
        if (!mem_wr) pend.push_back('{cyc + lat, mem_addr ^ 16'h5A5A});
      end else chk("mem_idle", {wr_done, mem_wr, mem_addr, mem_data_out}, 0);
      if (icache_data_valid || dcache_data_valid || fill_done) begin
        ret_seen++;
        if (fill_done) done_cyc = cyc;
        if (exp_ret.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL ret_unexpected: got data %h expected none", fill_data);
        end else begin
          re = exp_ret.pop_front();
          chk("fill_return", {icache_data_valid, dcache_data_valid, fill_data, fill_done},
              {re.iv, re.dv, re.data, re.done});
        end
      end else chk("fill_data_idle", fill_data, 0);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    int c, g, tgt, n;
    #1 chk("reset_outputs", outs(), 0);
    repeat (3) @(negedge clk);
    chk("reset_hold_outputs", outs(), 0);
    rst = 0;
    pend.push_back('{cyc + 2, 16'h1234});
    repeat (4) @(negedge clk);
    // I-cache fill, request pulsed for one cycle only
    lat = 4; c = cyc;
    icache_addr = 16'h1236; icache_req = 1; push_fill(0, 16'h1236);
    @(negedge clk); icache_req = 0;
    track_fill(0, c + 1, 0, g);
    // D-cache fill at shortest latency
    lat = 1; c = cyc;
    dcache_addr = 16'h2A5F; dcache_req = 1; push_fill(1, 16'h2A5F);
    @(negedge clk); dcache_req = 0;
    track_fill(1, c + 1, 0, g);
    // Store beats both misses, then round-robin I, D, I at longest latency
    lat = 6; c = cyc;
    dcache_wr_req = 1; dcache_wr_addr = 16'h0040; dcache_wr_data = 16'hBEEF;
    icache_req = 1; icache_addr = 16'h0100; dcache_req = 1; dcache_addr = 16'h0FF8;
    exp_mem.push_back('{1'b1, 16'h0040, 16'hBEEF});
    push_fill(0, 16'h0100); push_fill(1, 16'h0FF8); push_fill(0, 16'h0100);
    @(negedge clk);
    chk("store_grant", {icache_grant, dcache_grant, wr_done, mem_wr}, 4'b0111);
    dcache_wr_req = 0;
    @(negedge clk);
    chk("store_idle_gap", {icache_grant, dcache_grant}, 0);
    track_fill(0, c + 3, 0, g);
    track_fill(1, g + lat + WORDS + 1, 0, g);
    track_fill(0, g + lat + WORDS + 1, 1, g);
    // Asynchronous reset after three returned words
    lat = 4; c = cyc;
    icache_addr = 16'h8008; icache_req = 1; push_fill(0, 16'h8008);
    @(negedge clk); icache_req = 0;
    chk("rst_test_grant", {icache_grant, cyc}, {1'b1, c + 1});
    tgt = ret_seen + 3; n = 0;
    while (ret_seen < tgt && n < 30) begin @(negedge clk); #2; n++; end
    rst = 1;
    #1 chk("async_reset_outputs", outs(), 0);
    exp_mem.delete(); exp_ret.delete();
    @(negedge clk);
    chk("reset_stale_outputs", outs(), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    n = 0;
    while (pend.size() > 0 && n < 20) begin @(negedge clk); n++; end
    chk("stale_drained", pend.size(), 0);
    @(negedge clk);
    c = cyc;
    dcache_addr = 16'h4444; dcache_req = 1; push_fill(1, 16'h4444);
    @(negedge clk); dcache_req = 0;
    track_fill(1, c + 1, 0, g);
    repeat (3) @(negedge clk);
    chk("mem_queue_empty", exp_mem.size(), 0);
    chk("ret_queue_empty", exp_ret.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
